// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module     : ps2_pkg
// Description: Shared constants and types for the PS/2 key decoder: scan-code
//              prefix bytes, decoder FSM state encoding and the key event
//              record handed from byte processing to the output registers.
// Revision   : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK = 8'hF0;  // break (key release) prefix

  // Decoder FSM: one state to sample the FIFO head, one to pop and process it
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    POP  = 1'b1
  } ps2_state_e;

  // Folded key event; rel = break, rpt = typematic repeat of the held key
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rpt;
  } ps2_event_t;

endpackage
`default_nettype wire

// File: rtl/ps2_scan2ascii.sv
`default_nettype none
// ============================================================================
// Module     : ps2_scan2ascii
// Description: Combinational set-2 make-code to ASCII lookup. Codes outside
//              the table map to 8'h00.
// Ports      : code  - input  [7:0] set-2 scan code (prefixes stripped)
//              ascii - output [7:0] ASCII character, 8'h00 if unmapped
// Revision   : 1.0 - initial release
// ============================================================================
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C:   ascii = 8'h61;  // a
      8'h32:   ascii = 8'h62;  // b
      8'h21:   ascii = 8'h63;  // c
      8'h45:   ascii = 8'h30;  // 0
      8'h16:   ascii = 8'h31;  // 1
      8'h29:   ascii = 8'h20;  // space
      8'h5A:   ascii = 8'h0D;  // enter
      default: ascii = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module     : ps2_key_decoder
// Description: Drains the PS/2 receiver FIFO one byte every two cycles,
//              folds E0/F0 prefixes into single key events, tracks the held
//              key, flags typematic repeats and counts fresh key presses.
// Ports      : clk, rst        - clock, asynchronous active-high reset
//              ready, data     - receiver FIFO non-empty flag and head byte
//              nextdata_n      - registered active-low pop strobe
//              key_valid       - one-cycle event strobe
//              key_code/ext/release/repeat/ascii - event fields, held
//                                until the next event
//              key_held, held_code - currently held key
//              press_count     - non-repeat make events, wraps at 2^CNT_W
// Revision   : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_count
);

  ps2_state_e       r_state;
  logic [7:0]       r_byte;
  logic             r_nextdata_n;
  logic             r_ext_flag;
  logic             r_brk_flag;
  logic             r_valid;
  ps2_event_t       r_evt;
  logic [7:0]       r_ascii;
  logic             r_held;
  logic             r_held_ext;
  logic [7:0]       r_held_code;
  logic [CNT_W-1:0] r_count;

  logic [7:0]       w_rom_ascii;
  logic             w_held_match;
  ps2_event_t       w_evt;

  ps2_scan2ascii u_scan2ascii (
    .code  (r_byte),
    .ascii (w_rom_ascii)
  );

  // The held key is identified by {ext, code}: E0 75 and 75 are different keys.
  always_comb begin
    w_held_match = r_held && (r_held_ext == r_ext_flag) && (r_held_code == r_byte);
    w_evt        = '0;
    w_evt.code   = r_byte;
    w_evt.ext    = r_ext_flag;
    w_evt.rel    = r_brk_flag;
    w_evt.rpt    = !r_brk_flag && w_held_match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_byte       <= '0;
      r_nextdata_n <= 1'b1;
      r_ext_flag   <= 1'b0;
      r_brk_flag   <= 1'b0;
      r_valid      <= 1'b0;
      r_evt        <= '0;
      r_ascii      <= '0;
      r_held       <= 1'b0;
      r_held_ext   <= 1'b0;
      r_held_code  <= '0;
      r_count      <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ready) begin
            r_byte       <= data;
            r_nextdata_n <= 1'b0;
            r_state      <= POP;
          end
        end
        POP: begin
          // Returning to IDLE for a cycle gives the receiver time to advance
          // its read pointer before ready is sampled again.
          r_nextdata_n <= 1'b1;
          r_state      <= IDLE;
          if (r_byte == SC_EXT) begin
            r_ext_flag <= 1'b1;
          end else if (r_byte == SC_BRK) begin
            r_brk_flag <= 1'b1;
          end else begin
            r_ext_flag <= 1'b0;
            r_brk_flag <= 1'b0;
            r_valid    <= 1'b1;
            r_evt      <= w_evt;
            r_ascii    <= (r_ext_flag || r_brk_flag) ? 8'h00 : w_rom_ascii;
            if (r_brk_flag) begin
              // Only releasing the held key clears it; held_code is retained.
              if (w_held_match) begin
                r_held <= 1'b0;
              end
            end else if (!w_held_match) begin
              r_count     <= r_count + 1'b1;
              r_held      <= 1'b1;
              r_held_ext  <= r_ext_flag;
              r_held_code <= r_byte;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign nextdata_n  = r_nextdata_n;
  assign key_valid   = r_valid;
  assign key_code    = r_evt.code;
  assign key_ext     = r_evt.ext;
  assign key_release = r_evt.rel;
  assign key_repeat  = r_evt.rpt;
  assign key_ascii   = r_ascii;
  assign key_held    = r_held;
  assign held_code   = r_held_code;
  assign press_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module     : tb_ps2_key_decoder
// Description: Directed self-checking bench for ps2_key_decoder. A small
//              receiver FIFO model feeds bytes through the ready/nextdata_n
//              handshake; key events and pop strobes are logged and compared
//              with hand-computed expectations.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

  localparam int CNT_W = 8;

  typedef struct {
    int         cyc;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rpt;
    logic [7:0] ascii;
    logic [7:0] held_code;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [7:0]       data;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic             key_repeat;
  logic [7:0]       key_ascii;
  logic             key_held;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] press_count;

  logic [7:0] fifo[$];
  ev_t        evq[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         t_ready = 0;
  int         n_pass = 0;
  int         n_total = 0;

  ps2_key_decoder #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .data        (data),
    .nextdata_n  (nextdata_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .key_ascii   (key_ascii),
    .key_held    (key_held),
    .held_code   (held_code),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_ev(input string tag, input int idx, input logic [7:0] code,
                          input logic ext, input logic rel, input logic rpt,
                          input logic [7:0] ascii);
    if (idx >= evq.size()) begin
      check({tag, "_present"}, 32'(evq.size()), 32'(idx + 1));
    end else begin
      check({tag, "_code"},  evq[idx].code,  code);
      check({tag, "_ext"},   evq[idx].ext,   ext);
      check({tag, "_rel"},   evq[idx].rel,   rel);
      check({tag, "_rpt"},   evq[idx].rpt,   rpt);
      check({tag, "_ascii"}, evq[idx].ascii, ascii);
    end
  endtask

  // Receiver model plus monitor, all on the falling edge so DUT outputs are
  // stable and inputs settle well before the next rising edge.
  initial begin
    logic ready_prev;
    ready = 1'b0;
    data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (key_valid)
        evq.push_back('{cyc, key_code, key_ext, key_release, key_repeat, key_ascii, held_code});
      if (!nextdata_n) begin
        pop_cyc.push_back(cyc);
        if (fifo.size() != 0) void'(fifo.pop_front());
      end
      ready_prev = ready;
      ready = (fifo.size() != 0);
      data  = ready ? fifo[0] : 8'h00;
      if (ready && !ready_prev) t_ready = cyc;
    end
  end

  task automatic start_test();
    @(posedge clk);
    #2;
    evq.delete();
    pop_cyc.delete();
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drained"}, (fifo.size() == 0), 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_nextdata_n", nextdata_n, 1'b1);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_fields", {key_code, key_ext, key_release, key_repeat, key_ascii}, 32'h0);
    check("rst_held", {key_held, held_code}, 32'h0);
    check("rst_count", press_count, 8'h00);

    // Single make with handshake timing
    start_test();
    push(8'h1C);
    drain("t1", 100);
    check("t1_pops", pop_cyc.size(), 1);
    if (pop_cyc.size() > 0) check("t1_pop_lat", pop_cyc[0] - t_ready, 1);
    check("t1_events", evq.size(), 1);
    if (evq.size() > 0) check("t1_valid_lat", evq[0].cyc - t_ready, 2);
    check_ev("t1_ev", 0, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
    check("t1_count", press_count, 8'd1);
    check("t1_held", key_held, 1'b1);
    check("t1_held_code", held_code, 8'h1C);

    // Typematic repeats and release
    do_reset();
    start_test();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain("t2", 100);
    check("t2_events", evq.size(), 4);
    check_ev("t2_ev0", 0, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
    check_ev("t2_ev1", 1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h61);
    check_ev("t2_ev2", 2, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h61);
    check_ev("t2_ev3", 3, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00);
    check("t2_count", press_count, 8'd1);
    check("t2_held", key_held, 1'b0);
    check("t2_held_code", held_code, 8'h1C);
    check("t2_pops", pop_cyc.size(), 5);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("t2_pop_gap", pop_cyc[i] - pop_cyc[i-1], 2);

    // Extended make, both release prefix orders, duplicate prefix
    do_reset();
    start_test();
    push(8'hE0); push(8'h75);
    push(8'hE0); push(8'hF0); push(8'h75);
    push(8'hF0); push(8'hE0); push(8'h75);
    push(8'hE0); push(8'hE0); push(8'h75);
    drain("t3", 200);
    check("t3_events", evq.size(), 4);
    check_ev("t3_make", 0, 8'h75, 1'b1, 1'b0, 1'b0, 8'h00);
    check_ev("t3_brk_ef", 1, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00);
    check_ev("t3_brk_fe", 2, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00);
    check_ev("t3_dup_ext", 3, 8'h75, 1'b1, 1'b0, 1'b0, 8'h00);
    check("t3_count", press_count, 8'd2);
    check("t3_held", key_held, 1'b1);

    // Non-matching break keeps the newer held key
    do_reset();
    start_test();
    push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
    drain("t4", 100);
    check("t4_events", evq.size(), 3);
    if (evq.size() > 1) check("t4_held_after_b", evq[1].held_code, 8'h32);
    check_ev("t4_b", 1, 8'h32, 1'b0, 1'b0, 1'b0, 8'h62);
    check_ev("t4_brk", 2, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00);
    check("t4_held", key_held, 1'b1);
    check("t4_held_code", held_code, 8'h32);
    check("t4_count", press_count, 8'd2);

    // Counter wrap
    do_reset();
    start_test();
    for (int i = 0; i < 255; i++) begin
      push(8'h1C); push(8'hF0); push(8'h1C);
    end
    drain("t5a", 4000);
    check("t5_count_255", press_count, 8'hFF);
    check("t5_held_pre", key_held, 1'b0);
    start_test();
    push(8'h1C);
    drain("t5b", 100);
    check("t5_count_wrap", press_count, 8'h00);
    check("t5_held", key_held, 1'b1);

    // Reset mid-sequence clears the pending prefix
    do_reset();
    start_test();
    push(8'hE0);
    drain("t6a", 100);
    check("t6_no_event", evq.size(), 0);
    do_reset();
    @(negedge clk);
    #1;
    check("t6_rst_nextdata_n", nextdata_n, 1'b1);
    check("t6_rst_fields", {key_valid, key_code, key_ext, key_release, key_repeat}, 32'h0);
    check("t6_rst_state", {key_ascii, key_held, held_code, press_count}, 32'h0);
    start_test();
    push(8'h29);
    push(8'h45); push(8'hF0); push(8'h45); push(8'h16); push(8'h5A); push(8'h1D);
    drain("t6b", 200);
    check("t6_events", evq.size(), 6);
    check_ev("t6_space", 0, 8'h29, 1'b0, 1'b0, 1'b0, 8'h20);
    check_ev("t6_zero", 1, 8'h45, 1'b0, 1'b0, 1'b0, 8'h30);
    check_ev("t6_one", 3, 8'h16, 1'b0, 1'b0, 1'b0, 8'h31);
    check_ev("t6_enter", 4, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h0D);
    check_ev("t6_unmapped", 5, 8'h1D, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_count", press_count, 8'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
